// File: rtl/read_return_queue.sv
// Read return queue: tracks the burst size of every outstanding DRAM read and
// queues the masked read words for the host on a valid/ready interface.

package read_return_queue_pkg;
    typedef enum logic [1:0] {
        ONE_BYTE    = 2'd0,
        TWO_BYTES   = 2'd1,
        FOUR_BYTES  = 2'd2,
        EIGHT_BYTES = 2'd3
    } burst_size_t;
endpackage

module read_return_queue
    import read_return_queue_pkg::*;
#(
    parameter int TAG_DEPTH  = 4,
    parameter int DATA_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              read_issued,
    input  burst_size_t                       read_size,
    output logic                              read_ready,
    output burst_size_t                       rburst_size_pop,
    input  logic                              dram_strobe,
    input  logic [63:0]                       dram_data,
    output logic                              rdata_valid,
    input  logic                              rdata_ready,
    output logic [63:0]                       rdata,
    output burst_size_t                       rdata_size,
    output logic [$clog2(TAG_DEPTH+1)-1:0]    tag_count,
    output logic [$clog2(DATA_DEPTH+1)-1:0]   data_count,
    input  logic                              err_clear,
    output logic                              err_overflow,
    output logic                              err_underflow
);

    localparam int TPW = $clog2(TAG_DEPTH);
    localparam int TCW = $clog2(TAG_DEPTH + 1);
    localparam int DPW = $clog2(DATA_DEPTH);
    localparam int DCW = $clog2(DATA_DEPTH + 1);

    localparam logic [TCW-1:0] TAG_FULL_CNT  = TCW'(TAG_DEPTH);
    localparam logic [DCW-1:0] DATA_FULL_CNT = DCW'(DATA_DEPTH);
    localparam logic [TPW-1:0] TPTR_ONE      = TPW'(1);
    localparam logic [DPW-1:0] DPTR_ONE      = DPW'(1);
    localparam logic [TCW-1:0] TCNT_ONE      = TCW'(1);
    localparam logic [DCW-1:0] DCNT_ONE      = DCW'(1);

    // Tag FIFO storage and pointers
    burst_size_t    tag_mem [TAG_DEPTH];
    logic [TPW-1:0] tag_wr_ptr;
    logic [TPW-1:0] tag_rd_ptr;

    // Data FIFO storage and pointers
    logic [63:0]    data_word_mem [DATA_DEPTH];
    burst_size_t    data_size_mem [DATA_DEPTH];
    logic [DPW-1:0] data_wr_ptr;
    logic [DPW-1:0] data_rd_ptr;

    logic        tag_full, tag_empty, tag_push, tag_pop;
    logic        data_full, data_empty, data_push, data_pop;
    burst_size_t head_size;
    logic [63:0] masked_word;
    logic        overflow_event, underflow_event;

    // Status is derived from the registered counts only, so read_ready has
    // no combinational path from read_issued.
    assign tag_full   = (tag_count == TAG_FULL_CNT);
    assign tag_empty  = (tag_count == '0);
    assign data_full  = (data_count == DATA_FULL_CNT);
    assign data_empty = (data_count == '0);

    assign read_ready = !tag_full;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // push that coincides with a pop.
    assign tag_pop   = dram_strobe && !tag_empty;
    assign tag_push  = read_issued && (!tag_full || tag_pop);
    assign data_pop  = rdata_valid && rdata_ready;
    assign data_push = dram_strobe && (!data_full || data_pop);

    assign rburst_size_pop = tag_empty ? ONE_BYTE : tag_mem[tag_rd_ptr];

    // A strobe with no tag outstanding keeps the whole word.
    assign head_size = tag_empty ? EIGHT_BYTES : tag_mem[tag_rd_ptr];

    assign rdata_valid = !data_empty;
    assign rdata       = data_empty ? 64'd0 : data_word_mem[data_rd_ptr];
    assign rdata_size  = data_empty ? ONE_BYTE : data_size_mem[data_rd_ptr];

    assign overflow_event  = (read_issued && tag_full && !tag_pop) ||
                             (dram_strobe && data_full && !data_pop);
    assign underflow_event = dram_strobe && tag_empty;

    // Zero the byte lanes beyond the burst size of the head tag
    always_comb begin
        // NOTE: default first so every path assigns masked_word; otherwise a latch is inferred.
        masked_word = '0;
        case (head_size)
            ONE_BYTE:    masked_word[7:0]  = dram_data[7:0];
            TWO_BYTES:   masked_word[15:0] = dram_data[15:0];
            FOUR_BYTES:  masked_word[31:0] = dram_data[31:0];
            EIGHT_BYTES: masked_word       = dram_data;
            default:     masked_word       = '0;
        endcase
    end

    // Tag FIFO storage write
    // NOTE: storage arrays have no reset; the counts alone decide what is valid.
    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem[tag_wr_ptr] <= read_size;
        end
    end

    // Tag FIFO pointers and occupancy
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_count  <= '0;
        end else begin
            if (tag_push) tag_wr_ptr <= tag_wr_ptr + TPTR_ONE;
            if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + TPTR_ONE;
            if (tag_push && !tag_pop)      tag_count <= tag_count + TCNT_ONE;
            else if (!tag_push && tag_pop) tag_count <= tag_count - TCNT_ONE;
        end
    end

    // Data FIFO storage write
    always_ff @(posedge clk) begin
        if (data_push) begin
            data_word_mem[data_wr_ptr] <= masked_word;
            data_size_mem[data_wr_ptr] <= head_size;
        end
    end

    // Data FIFO pointers and occupancy
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_wr_ptr <= '0;
            data_rd_ptr <= '0;
            data_count  <= '0;
        end else begin
            if (data_push) data_wr_ptr <= data_wr_ptr + DPTR_ONE;
            if (data_pop)  data_rd_ptr <= data_rd_ptr + DPTR_ONE;
            if (data_push && !data_pop)      data_count <= data_count + DCNT_ONE;
            else if (!data_push && data_pop) data_count <= data_count - DCNT_ONE;
        end
    end

    // Sticky error flags; a new error wins over a simultaneous clear
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (overflow_event)  err_overflow <= 1'b1;
            else if (err_clear)  err_overflow <= 1'b0;
            if (underflow_event) err_underflow <= 1'b1;
            else if (err_clear)  err_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_read_return_queue.sv
// Self-checking bench for read_return_queue: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.

module tb_read_return_queue;
    import read_return_queue_pkg::*;

    localparam int TD = 4;
    localparam int DD = 4;

    logic                      clk;
    logic                      n_rst;
    logic                      read_issued;
    burst_size_t               read_size;
    logic                      read_ready;
    burst_size_t               rburst_size_pop;
    logic                      dram_strobe;
    logic [63:0]               dram_data;
    logic                      rdata_valid;
    logic                      rdata_ready;
    logic [63:0]               rdata;
    burst_size_t               rdata_size;
    logic [$clog2(TD+1)-1:0]   tag_count;
    logic [$clog2(DD+1)-1:0]   data_count;
    logic                      err_clear;
    logic                      err_overflow;
    logic                      err_underflow;

    read_return_queue #(.TAG_DEPTH(TD), .DATA_DEPTH(DD)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .read_issued     (read_issued),
        .read_size       (read_size),
        .read_ready      (read_ready),
        .rburst_size_pop (rburst_size_pop),
        .dram_strobe     (dram_strobe),
        .dram_data       (dram_data),
        .rdata_valid     (rdata_valid),
        .rdata_ready     (rdata_ready),
        .rdata           (rdata),
        .rdata_size      (rdata_size),
        .tag_count       (tag_count),
        .data_count      (data_count),
        .err_clear       (err_clear),
        .err_overflow    (err_overflow),
        .err_underflow   (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain queues of outstanding tags and returned words
    burst_size_t m_tag[$];
    logic [63:0] m_word[$];
    burst_size_t m_size[$];
    bit          m_ovf;
    bit          m_unf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mask_of(input logic [63:0] w, input burst_size_t s);
        int bytes;
        bytes = 1 << int'(s);
        if (bytes == 8) return w;
        return w & ((64'd1 << (8 * bytes)) - 64'd1);
    endfunction

    task automatic model_reset();
        m_tag.delete();
        m_word.delete();
        m_size.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_check();
        check("read_ready",      read_ready,      m_tag.size() < TD);
        check("rburst_size_pop", rburst_size_pop, (m_tag.size() > 0) ? m_tag[0] : ONE_BYTE);
        check("rdata_valid",     rdata_valid,     m_word.size() > 0);
        check("rdata",           rdata,           (m_word.size() > 0) ? m_word[0] : 64'd0);
        check("rdata_size",      rdata_size,      (m_size.size() > 0) ? m_size[0] : ONE_BYTE);
        check("tag_count",       tag_count,       m_tag.size());
        check("data_count",      data_count,      m_word.size());
        check("err_overflow",    err_overflow,    m_ovf);
        check("err_underflow",   err_underflow,   m_unf);
    endtask

    task automatic model_step(input bit ri, input burst_size_t rs, input bit st,
                              input logic [63:0] dd, input bit rr, input bit ec);
        int          tn;
        int          dn;
        bit          tpop, dpop, tacc, dacc, new_ovf, new_unf;
        burst_size_t sz;
        tn      = m_tag.size();
        dn      = m_word.size();
        tpop    = st && (tn > 0);
        sz      = (tn > 0) ? m_tag[0] : EIGHT_BYTES;
        dpop    = rr && (dn > 0);
        tacc    = ri && ((tn < TD) || tpop);
        dacc    = st && ((dn < DD) || dpop);
        new_ovf = (ri && !tacc) || (st && !dacc);
        new_unf = st && (tn == 0);
        m_ovf   = new_ovf ? 1'b1 : (ec ? 1'b0 : m_ovf);
        m_unf   = new_unf ? 1'b1 : (ec ? 1'b0 : m_unf);
        if (tpop) void'(m_tag.pop_front());
        if (dpop) begin
            void'(m_word.pop_front());
            void'(m_size.pop_front());
        end
        if (tacc) m_tag.push_back(rs);
        if (dacc) begin
            m_word.push_back(mask_of(dd, sz));
            m_size.push_back(sz);
        end
    endtask

    // One clock: drive inputs, compare against the model, advance both.
    task automatic cycle(input bit ri, input burst_size_t rs, input bit st,
                         input logic [63:0] dd, input bit rr, input bit ec);
        read_issued = ri;
        read_size   = rs;
        dram_strobe = st;
        dram_data   = dd;
        rdata_ready = rr;
        err_clear   = ec;
        model_check();
        model_step(ri, rs, st, dd, rr, ec);
        @(posedge clk);
        #1;
        read_issued = 1'b0;
        read_size   = ONE_BYTE;
        dram_strobe = 1'b0;
        dram_data   = 64'd0;
        rdata_ready = 1'b0;
        err_clear   = 1'b0;
    endtask

    typedef struct {
        bit          ri;
        burst_size_t rs;
        bit          st;
        logic [63:0] dd;
        bit          rr;
        int          tcnt;
        int          dcnt;
        bit          valid;
        logic [63:0] rdata;
        burst_size_t rsize;
        burst_size_t rburst;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Expected values are the state after the vector's clock edge
        vecs[0] = '{1'b1, FOUR_BYTES,  1'b0, 64'd0,                  1'b0, 1, 0, 1'b0, 64'd0,                  ONE_BYTE,    FOUR_BYTES};
        vecs[1] = '{1'b0, ONE_BYTE,    1'b1, 64'h1122334455667788,   1'b0, 0, 1, 1'b1, 64'h0000000055667788,   FOUR_BYTES,  ONE_BYTE};
        vecs[2] = '{1'b0, ONE_BYTE,    1'b0, 64'd0,                  1'b1, 0, 0, 1'b0, 64'd0,                  ONE_BYTE,    ONE_BYTE};
        vecs[3] = '{1'b1, ONE_BYTE,    1'b0, 64'd0,                  1'b0, 1, 0, 1'b0, 64'd0,                  ONE_BYTE,    ONE_BYTE};
        vecs[4] = '{1'b1, TWO_BYTES,   1'b0, 64'd0,                  1'b0, 2, 0, 1'b0, 64'd0,                  ONE_BYTE,    ONE_BYTE};
        vecs[5] = '{1'b1, EIGHT_BYTES, 1'b0, 64'd0,                  1'b1, 3, 0, 1'b0, 64'd0,                  ONE_BYTE,    ONE_BYTE};
        vecs[6] = '{1'b0, ONE_BYTE,    1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2, 1, 1'b1, 64'hFF,                 ONE_BYTE,    TWO_BYTES};
        vecs[7] = '{1'b0, ONE_BYTE,    1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, 1, 1'b1, 64'hFFFF,               TWO_BYTES,   EIGHT_BYTES};
        vecs[8] = '{1'b0, ONE_BYTE,    1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, EIGHT_BYTES, ONE_BYTE};
        vecs[9] = '{1'b0, ONE_BYTE,    1'b0, 64'd0,                  1'b1, 0, 0, 1'b0, 64'd0,                  ONE_BYTE,    ONE_BYTE};

        n_rst       = 1'b0;
        read_issued = 1'b0;
        read_size   = ONE_BYTE;
        dram_strobe = 1'b0;
        dram_data   = 64'd0;
        rdata_ready = 1'b0;
        err_clear   = 1'b0;
        model_reset();
        #12;
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check("reset read_ready",  read_ready,  1'b1);
        check("reset rdata_valid", rdata_valid, 1'b0);
        check("reset rdata",       rdata,       64'd0);
        check("reset rburst",      rburst_size_pop, ONE_BYTE);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].ri, vecs[i].rs, vecs[i].st, vecs[i].dd, vecs[i].rr, 1'b0);
            check($sformatf("vec%0d tag_count", i),   tag_count,       vecs[i].tcnt);
            check($sformatf("vec%0d data_count", i),  data_count,      vecs[i].dcnt);
            check($sformatf("vec%0d rdata_valid", i), rdata_valid,     vecs[i].valid);
            check($sformatf("vec%0d rdata", i),       rdata,           vecs[i].rdata);
            check($sformatf("vec%0d rdata_size", i),  rdata_size,      vecs[i].rsize);
            check($sformatf("vec%0d rburst", i),      rburst_size_pop, vecs[i].rburst);
        end

        // Data FIFO overflow with the host stalled
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, EIGHT_BYTES, 1'b0, 64'd0, 1'b0, 1'b0);
            cycle(1'b0, ONE_BYTE, 1'b1, 64'hC0DE_0000_0000_0000 + 64'(i), 1'b0, 1'b0);
        end
        check("ovf data_count",   data_count,   4);
        check("ovf tag_count",    tag_count,    0);
        check("ovf err_overflow", err_overflow, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain word%0d", i), rdata, 64'hC0DE_0000_0000_0000 + 64'(i));
            cycle(1'b0, ONE_BYTE, 1'b0, 64'd0, 1'b1, 1'b0);
        end
        check("drain empty", rdata_valid, 1'b0);
        cycle(1'b0, ONE_BYTE, 1'b0, 64'd0, 1'b0, 1'b1);
        check("ovf cleared", err_overflow, 1'b0);

        // Full tag FIFO accepts a push that coincides with a pop
        for (int i = 0; i < 4; i++) cycle(1'b1, ONE_BYTE, 1'b0, 64'd0, 1'b0, 1'b0);
        check("tag full count", tag_count,  4);
        check("tag full ready", read_ready, 1'b0);
        cycle(1'b1, TWO_BYTES, 1'b1, 64'h1234, 1'b1, 1'b0);
        check("push+pop tag_count", tag_count,    4);
        check("push+pop no error",  err_overflow, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, ONE_BYTE, 1'b1, 64'hABCD, 1'b1, 1'b0);
        check("tags drained", tag_count, 0);
        check("last size TWO", rdata_size, TWO_BYTES);
        cycle(1'b0, ONE_BYTE, 1'b0, 64'd0, 1'b1, 1'b0);

        // Strobe with no tag outstanding
        cycle(1'b0, ONE_BYTE, 1'b1, 64'hA5, 1'b0, 1'b0);
        check("unf flag",  err_underflow, 1'b1);
        check("unf rdata", rdata,         64'hA5);
        check("unf size",  rdata_size,    EIGHT_BYTES);
        cycle(1'b0, ONE_BYTE, 1'b0, 64'd0, 1'b1, 1'b1);
        check("unf cleared", err_underflow, 1'b0);

        // Asynchronous reset with entries held
        cycle(1'b0, ONE_BYTE, 1'b1, 64'h77, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, FOUR_BYTES, 1'b0, 64'd0, 1'b0, 1'b0);
        cycle(1'b0, ONE_BYTE, 1'b1, 64'h99, 1'b0, 1'b0);
        check("pre-rst tag_count",  tag_count,     2);
        check("pre-rst data_count", data_count,    2);
        check("pre-rst unf",        err_underflow, 1'b1);
        #2;
        n_rst = 1'b0;
        #1;
        check("async rst tag_count",   tag_count,     0);
        check("async rst data_count",  data_count,    0);
        check("async rst rdata_valid", rdata_valid,   1'b0);
        check("async rst read_ready",  read_ready,    1'b1);
        check("async rst err_ovf",     err_overflow,  1'b0);
        check("async rst err_unf",     err_underflow, 1'b0);
        model_reset();
        #2;
        n_rst = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) < 50),
                  burst_size_t'($urandom_range(0, 3)),
                  ($urandom_range(0, 99) < 40),
                  {$urandom, $urandom},
                  ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 99) < 10));
        end
        model_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
